dps20_tsv_arbiter: RTL and testbench
====================================

Name: dps20_tsv_arbiter

Overview:
- Shares one DPS_encoder_20 / 20-TSV bundle among NUM_REQ requesters.
- Round-robin grant. Each burst is framed by one header codeword carrying the requester ID, and bursts are capped at MAX_BURST beats.
- Screens every beat against the DPS-20 code range.
- Sits in front of the encoder's datain/clock domain; the receive side uses the header to demultiplex decoder output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DLEN, 15, codeword index width; equals `DBLEN20.
- CODE_MAX, 21892, number of valid DPS-20 codewords; legal indices are 0..CODE_MAX-1.
- MAX_BURST, 8, maximum data beats per grant (1..255).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DLEN  per-requester index; requester k occupies bits [k*DLEN +: DLEN].
- req_last  in  NUM_REQ  marks the final beat of a requester's burst.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- enc_data  out  DLEN  index to encoder datain.
- enc_valid  out  1  enc_data carries a header or data beat this cycle.
- enc_hdr  out  1  enc_data is a header codeword.
- grant_id  out  3  currently or most recently granted requester.
- range_err  out  1  one-cycle pulse when an out-of-range beat is consumed.
- err_count  out  16  saturating count of range errors.

Behaviour:
- Reserved indices: HDR_BASE = CODE_MAX - NUM_REQ (21888 by default). The header for requester k is HDR_BASE + k. Legal data is 0..HDR_BASE-1.
- Reset values: state IDLE, enc_data 0, enc_valid 0, enc_hdr 0, grant_id 0, range_err 0, err_count 0, req_ready all 0, rr pointer NUM_REQ-1 (so requester 0 has first priority after reset).
- A reset asserted mid-burst aborts the burst. There is no trailer and nothing is flushed. Outputs take reset values in the next cycle.
- All enc_* outputs, range_err and err_count are registered. A header or beat produced in cycle t appears on enc_* in cycle t+1.
- req_ready is combinational from the registered state and is high only in DATA, for the granted requester.
- FSM states:
  - IDLE: scan requesters pointer+1, pointer+2, … modulo NUM_REQ. The first one with req_valid=1 wins: latch grant_id, set pointer=grant_id, go to HDR. If none is valid, stay in IDLE. enc_valid=0 next cycle.
  - HDR (exactly 1 cycle): next cycle enc_data = HDR_BASE + grant_id, enc_valid=1, enc_hdr=1. Clear beat counter, go to DATA.
  - DATA:
    - If the granted requester has req_valid=1, the beat is accepted. Next cycle enc_valid=1, enc_hdr=0. Beat counter increments.
    - If req_data < HDR_BASE, enc_data = req_data. Otherwise enc_data = 0, range_err pulses, err_count increments (saturating at 16'hFFFF).
    - If req_valid=0, this is a bubble: enc_valid=0, enc_data holds its previous value (no TSV toggling), state stays DATA.
    - Exit to GAP when the accepted beat has req_last=1 or the counter reaches MAX_BURST; the accepted beat is still transmitted.
  - GAP (exactly 1 cycle): enc_valid=0, enc_data held. Go to IDLE.
- Minimum cycle between consecutive headers: 1 header + 1 beat + GAP + IDLE = 4 cycles.
- Beats from non-granted requesters are never consumed; their req_ready stays 0.
- req_valid from the granted requester dropping in DATA never ends the burst. Only req_last or MAX_BURST does.
- A requester whose burst was cut by MAX_BURST re-arbitrates normally. It gets a new header and has the lowest priority in the next round.
- Simultaneous range_err and err_count saturation: range_err still pulses; the count stays at FFFF.

Test Plan:
- Reset, then req_valid=4'b0001, req_data[0] sequence 5, 6, 7 with last on 7. Required enc_data: 21888 (hdr=1), then 5, 6, 7 with enc_valid=1, then one enc_valid=0 cycle. grant_id=0.
- All four requesters valid continuously, each burst length 1. Grant order 0, 1, 2, 3, 0. Headers 21888, 21889, 21890, 21891 in that order. No requester is granted twice before all others.
- Requester 2 streams 20 beats with no req_last, MAX_BURST=8. It receives 8 beats, then GAP, then a new header 21890 (no other requester valid), then 8 more, then 4. Beat count is exact.
- Requester 1 sends 21888, then 30000 wrapped to 15 bits (value 30000), then 100. Required output: 0, 0, 100. range_err pulses twice; err_count=2.
- Granted requester deasserts req_valid for 3 cycles mid-burst. enc_valid=0 for those cycles, enc_data unchanged, no new header, and the burst resumes.
- Assert reset in DATA after 2 beats. Next cycle all outputs are at reset values and req_ready=0. After release, requester 0 wins over simultaneously valid requester 3.

Source files
------------

// File: rtl/dps20_tsv_arbiter.sv
// rtl/dps20_tsv_arbiter.sv - round-robin arbiter sharing one DPS-20 encoder/TSV bundle
module dps20_tsv_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DLEN      = 15,
    parameter int CODE_MAX  = 21892,
    parameter int MAX_BURST = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DLEN-1:0] req_data,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [DLEN-1:0]         enc_data,
    output logic                    enc_valid,
    output logic                    enc_hdr,
    output logic [2:0]              grant_id,
    output logic                    range_err,
    output logic [15:0]             err_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    // Top NUM_REQ codewords are reserved as per-requester headers.
    localparam logic [DLEN-1:0] HDR_BASE    = DLEN'(CODE_MAX - NUM_REQ);
    localparam logic [8:0]      BURST_LIMIT = 9'(MAX_BURST);

    logic [1:0]      state;
    logic [2:0]      ptr;
    logic [7:0]      beat_cnt;

    logic [7:0]      valid_ext;
    logic [2:0]      idx;
    logic [2:0]      winner;
    logic            found;
    logic [DLEN-1:0] sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic [8:0]      beat_next;
    logic            burst_end;

    // Widen valid to 8 bits so a 3-bit rotating index is always in range.
    always_comb begin
        valid_ext = 8'(req_valid);
    end

    // Round-robin scan starting just after the last granted requester.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = 3'((int'(ptr) + i) % NUM_REQ);
            if (!found && valid_ext[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Multiplex the granted requester's beat, valid and last.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == 3'(k)) begin
                sel_data  = req_data[k*DLEN +: DLEN];
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
            end
        end
        beat_next = {1'b0, beat_cnt} + 9'd1;
        burst_end = sel_last || (beat_next == BURST_LIMIT);
    end

    // Accept only the granted requester, and only while its burst is open.
    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ready[k] = (state == S_DATA) && (grant_id == 3'(k));
        end
    end

    // Burst framing FSM with registered encoder-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= 3'(NUM_REQ - 1);
            beat_cnt  <= '0;
            grant_id  <= '0;
            enc_data  <= '0;
            enc_valid <= 1'b0;
            enc_hdr   <= 1'b0;
            range_err <= 1'b0;
            err_count <= '0;
        end else begin
            range_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    enc_valid <= 1'b0;
                    enc_hdr   <= 1'b0;
                    if (found) begin
                        grant_id <= winner;
                        ptr      <= winner;
                        state    <= S_HDR;
                    end
                end
                S_HDR: begin
                    enc_data  <= HDR_BASE + DLEN'(grant_id);
                    enc_valid <= 1'b1;
                    enc_hdr   <= 1'b1;
                    beat_cnt  <= '0;
                    state     <= S_DATA;
                end
                S_DATA: begin
                    enc_hdr <= 1'b0;
                    if (sel_valid) begin
                        enc_valid <= 1'b1;
                        beat_cnt  <= beat_next[7:0];
                        if (sel_data < HDR_BASE) begin
                            enc_data <= sel_data;
                        end else begin
                            // Out-of-range beats are replaced by 0 so no header is forged.
                            enc_data  <= '0;
                            range_err <= 1'b1;
                            if (err_count != 16'hFFFF) begin
                                err_count <= err_count + 16'd1;
                            end
                        end
                        if (burst_end) begin
                            state <= S_GAP;
                        end
                    end else begin
                        // Bubble: keep enc_data steady so the TSVs do not toggle.
                        enc_valid <= 1'b0;
                    end
                end
                S_GAP: begin
                    enc_valid <= 1'b0;
                    enc_hdr   <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dps20_tsv_arbiter.sv
// tb/tb_dps20_tsv_arbiter.sv - self-checking bench for dps20_tsv_arbiter
module tb_dps20_tsv_arbiter;

    localparam int N  = 4;
    localparam int DL = 15;
    localparam int CM = 21892;
    localparam int MB = 8;
    localparam int HB = CM - N;

    localparam int M_IDLE = 0;
    localparam int M_HDR  = 1;
    localparam int M_DATA = 2;
    localparam int M_GAP  = 3;

    logic            clock = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DL-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DL-1:0]   enc_data;
    logic            enc_valid;
    logic            enc_hdr;
    logic [2:0]      grant_id;
    logic            range_err;
    logic [15:0]     err_count;

    always #5 clock = ~clock;

    dps20_tsv_arbiter #(
        .NUM_REQ(N), .DLEN(DL), .CODE_MAX(CM), .MAX_BURST(MB)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .enc_data(enc_data), .enc_valid(enc_valid), .enc_hdr(enc_hdr),
        .grant_id(grant_id), .range_err(range_err), .err_count(err_count)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] bq [N][$];
    int vprob [N];
    int hold  [N];

    int m_mode, m_gid, m_ptr, m_beats, m_data, m_valid, m_hdr, m_err, m_cnt;

    int log_data[$];
    int log_hdr[$];
    int log_gid[$];
    int err_pulses;
    int exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_gid   = 0;
        m_ptr   = N - 1;
        m_beats = 0;
        m_data  = 0;
        m_valid = 0;
        m_hdr   = 0;
        m_err   = 0;
        m_cnt   = 0;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_hdr.delete();
        log_gid.delete();
        err_pulses = 0;
    endtask

    // One clock: drive, check ready, advance model, sample outputs after the edge.
    task automatic cycle();
        int consumed;
        int d;
        int exp_ready;
        consumed = -1;
        for (int k = 0; k < N; k++) begin
            if (bq[k].size() > 0 && hold[k] == 0 && $urandom_range(99) < vprob[k]) begin
                req_valid[k]          = 1'b1;
                req_data[k*DL +: DL]  = bq[k][0][14:0];
                req_last[k]           = bq[k][0][15];
            end else begin
                req_valid[k]          = 1'b0;
                req_data[k*DL +: DL]  = 15'($urandom);
                req_last[k]           = 1'($urandom);
            end
            if (hold[k] > 0) hold[k]--;
        end
        #1;
        exp_ready = (m_mode == M_DATA) ? (1 << m_gid) : 0;
        check("req_ready", int'(req_ready), exp_ready);

        if (reset) begin
            model_reset();
        end else begin
            m_err = 0;
            case (m_mode)
                M_IDLE: begin
                    m_valid = 0;
                    m_hdr   = 0;
                    for (int i = 1; i <= N; i++) begin
                        if (m_mode == M_IDLE && req_valid[(m_ptr + i) % N]) begin
                            m_gid  = (m_ptr + i) % N;
                            m_ptr  = m_gid;
                            m_mode = M_HDR;
                        end
                    end
                end
                M_HDR: begin
                    m_data  = HB + m_gid;
                    m_valid = 1;
                    m_hdr   = 1;
                    m_beats = 0;
                    m_mode  = M_DATA;
                end
                M_DATA: begin
                    m_hdr = 0;
                    if (req_valid[m_gid]) begin
                        consumed = m_gid;
                        m_valid  = 1;
                        m_beats++;
                        d = int'(req_data[m_gid*DL +: DL]);
                        if (d < HB) begin
                            m_data = d;
                        end else begin
                            m_data = 0;
                            m_err  = 1;
                            if (m_cnt < 65535) m_cnt++;
                        end
                        if (req_last[m_gid] || m_beats == MB) m_mode = M_GAP;
                    end else begin
                        m_valid = 0;
                    end
                end
                default: begin
                    m_valid = 0;
                    m_hdr   = 0;
                    m_mode  = M_IDLE;
                end
            endcase
        end

        @(posedge clock);
        #1;
        check("enc_valid", int'(enc_valid), m_valid);
        check("enc_hdr",   int'(enc_hdr),   m_hdr);
        check("enc_data",  int'(enc_data),  m_data);
        check("grant_id",  int'(grant_id),  m_gid);
        check("range_err", int'(range_err), m_err);
        check("err_count", int'(err_count), m_cnt);

        if (enc_valid) begin
            log_data.push_back(int'(enc_data));
            log_hdr.push_back(int'(enc_hdr));
            log_gid.push_back(int'(grant_id));
        end
        if (range_err) err_pulses++;
        if (consumed >= 0 && !reset) void'(bq[consumed].pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        int busy;
        n = 0;
        busy = 1;
        while (busy && n < budget) begin
            cycle();
            n++;
            busy = (m_mode != M_IDLE) ? 1 : 0;
            for (int k = 0; k < N; k++) if (bq[k].size() > 0) busy = 1;
        end
        check({name, "_done"}, busy, 0);
        cycle();
        cycle();
    endtask

    task automatic wait_size(input string name, input int k, input int sz, input int budget);
        int n;
        n = 0;
        while (bq[k].size() > sz && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_reached"}, (bq[k].size() <= sz) ? 1 : 0, 1);
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, log_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({name, "_beat"}, (i < log_data.size()) ? log_data[i] : -1, exp_q[i]);
        end
    endtask

    task automatic push_beat(input int k, input int data, input int last);
        bq[k].push_back({1'(last), 15'(data)});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] t;
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        for (int k = 0; k < N; k++) begin
            vprob[k] = 100;
            hold[k]  = 0;
        end
        model_reset();
        clear_log();
        cycle();
        cycle();
        check("rst_enc_valid", int'(enc_valid), 0);
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_err_count", int'(err_count), 0);
        check("rst_grant_id",  int'(grant_id),  0);
        reset = 1'b0;

        // Single short burst from requester 0.
        clear_log();
        push_beat(0, 5, 0);
        push_beat(0, 6, 0);
        push_beat(0, 7, 1);
        drain("t1", 50);
        exp_q = {21888, 5, 6, 7};
        check_log("t1");
        check("t1_hdr_flag", (log_hdr.size() > 0) ? log_hdr[0] : -1, 1);
        check("t1_grant", (log_gid.size() > 0) ? log_gid[0] : -1, 0);

        // All four contending with single-beat bursts.
        do_reset();
        clear_log();
        for (int k = 0; k < N; k++) push_beat(k, 100 + k, 1);
        push_beat(0, 200, 1);
        drain("t2", 100);
        exp_q = {21888, 100, 21889, 101, 21890, 102, 21891, 103, 21888, 200};
        check_log("t2");

        // MAX_BURST splitting of a 20-beat stream.
        clear_log();
        for (int i = 0; i < 20; i++) push_beat(2, 1000 + i, (i == 19) ? 1 : 0);
        drain("t3", 200);
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % MB == 0) exp_q.push_back(21890);
            exp_q.push_back(1000 + i);
        end
        check_log("t3");

        // Range screening.
        do_reset();
        clear_log();
        push_beat(1, 21888, 0);
        push_beat(1, 30000, 0);
        push_beat(1, 100, 1);
        drain("t4", 50);
        exp_q = {21889, 0, 0, 100};
        check_log("t4");
        check("t4_err_pulses", err_pulses, 2);
        check("t4_err_count", int'(err_count), 2);

        // Three-cycle bubble mid-burst.
        clear_log();
        for (int i = 0; i < 6; i++) push_beat(0, 10 + i, (i == 5) ? 1 : 0);
        wait_size("t5", 0, 4, 50);
        hold[0] = 3;
        drain("t5", 50);
        exp_q = {21888, 10, 11, 12, 13, 14, 15};
        check_log("t5");

        // Reset mid-burst, then priority restarts at requester 0.
        clear_log();
        for (int i = 0; i < 6; i++) push_beat(2, 500 + i, (i == 5) ? 1 : 0);
        wait_size("t6", 2, 4, 50);
        push_beat(0, 600, 1);
        push_beat(3, 700, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("t6_rst_valid", int'(enc_valid), 0);
        check("t6_rst_ready", int'(req_ready), 0);
        check("t6_rst_grant", int'(grant_id), 0);
        check("t6_rst_errcnt", int'(err_count), 0);
        clear_log();
        drain("t6", 100);
        exp_q = {21888, 600, 21890, 502, 503, 504, 505, 21891, 700};
        check_log("t6");

        // Randomized traffic with occasional resets.
        for (int k = 0; k < N; k++) vprob[k] = $urandom_range(100, 40);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                while (bq[k].size() < 2) begin
                    push_beat(k,
                              ($urandom_range(9) == 0) ? int'($urandom_range(32767, HB))
                                                       : int'($urandom_range(HB - 1)),
                              ($urandom_range(9) < 3) ? 1 : 0);
                end
            end
            reset = ($urandom_range(399) == 0) ? 1'b1 : 1'b0;
            cycle();
        end
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            vprob[k] = 100;
            if (bq[k].size() > 0) begin
                t = bq[k].pop_back();
                t[15] = 1'b1;
                bq[k].push_back(t);
            end
        end
        drain("rand", 500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
